// File: rtl/ccip_boundary_pkg.sv
// Shared CCI-P boundary types, the AFU reset state encoding and the Tx valid-mask helper.
package ccip_boundary_pkg;

  localparam int CCIP_MAX_STAGES = 4;

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2
  } t_rst_state;

  // Reduced-width CCI-P channel structs; field names follow the shell's naming.
  typedef struct packed {
    logic        valid;
    logic [31:0] hdr;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic        valid;
    logic [31:0] hdr;
    logic [63:0] data;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic        mmioRdValid;
    logic [8:0]  hdr;
    logic [63:0] data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

  typedef struct packed {
    logic        rspValid;
    logic        mmioRdValid;
    logic        mmioWrValid;
    logic [27:0] hdr;
    logic [63:0] data;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic        rspValid;
    logic [27:0] hdr;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  // Drops every request valid; payload is left untouched so only the qualifiers change.
  function automatic t_if_ccip_Tx f_mask_tx(input t_if_ccip_Tx tx);
    t_if_ccip_Tx masked;
    masked                = tx;
    masked.c0.valid       = 1'b0;
    masked.c1.valid       = 1'b0;
    masked.c2.mmioRdValid = 1'b0;
    return masked;
  endfunction

endpackage

// File: rtl/ccip_delay_line.sv
// Async-reset shift register of an arbitrary packed type; DEPTH=0 degenerates to a wire.
module ccip_delay_line #(
  parameter type T     = logic,
  parameter int  DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  T     d,
  output T     q
);

  if (DEPTH == 0) begin : gWire
    assign q = d;
  end else begin : gRegs
    T stages [DEPTH];

    // NOTE: every stage is reset (not just the last) so a stale valid cannot reappear after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else begin
        stages[0] <= d;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign q = stages[DEPTH-1];
  end

endmodule

// File: rtl/ccip_boundary_pipe.sv
// CCI-P boundary retiming between shell and AFU with a stretched AFU reset.
// Optional Rx/Tx statistics counters are built when CCIP_BOUNDARY_STATS_EN is defined.
module ccip_boundary_pipe
  import ccip_boundary_pkg::*;
#(
  parameter int RX_STAGES     = 2,
  parameter int TX_STAGES     = 2,
  parameter int RST_HOLD      = 16,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_rst_in,
  input  t_if_ccip_Rx sRx_in,
  output t_if_ccip_Tx sTx_out,
  output logic        afu_rst,
  output t_if_ccip_Rx afu_rx,
  input  t_if_ccip_Tx afu_tx
`ifdef CCIP_BOUNDARY_STATS_EN
  ,
  output logic [31:0] rx_rsp_cnt,
  output logic [31:0] tx_req_cnt
`endif
);

  if (RX_STAGES < 0 || RX_STAGES > CCIP_MAX_STAGES) begin : gBadRx
    $error("RX_STAGES must be within 0..%0d", CCIP_MAX_STAGES);
  end
  if (TX_STAGES < 0 || TX_STAGES > CCIP_MAX_STAGES) begin : gBadTx
    $error("TX_STAGES must be within 0..%0d", CCIP_MAX_STAGES);
  end
  if (RST_HOLD < 1 || RST_HOLD > 255) begin : gBadHold
    $error("RST_HOLD must be within 1..255");
  end
  if (RX_STAGES + TX_STAGES > ALMFULL_SLACK) begin : gBadSlack
    $error("RX_STAGES+TX_STAGES exceeds ALMFULL_SLACK");
  end

  localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD - 1);

  t_rst_state  rstState, rstStateNext;
  logic [7:0]  holdCnt, holdCntNext;
  logic        afuRst;
  t_if_ccip_Tx txGated;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstState <= ASSERT;
      holdCnt  <= '0;
      afuRst   <= 1'b1;
    end else begin
      rstState <= rstStateNext;
      holdCnt  <= holdCntNext;
      // Registered from the next state so afu_rst never glitches on state-bit changes.
      afuRst   <= (rstStateNext != RUN);
    end
  end

  // NOTE: defaults first keeps this block latch-free; combinational logic uses blocking '='.
  always_comb begin
    rstStateNext = rstState;
    holdCntNext  = holdCnt;
    unique case (rstState)
      ASSERT: begin
        if (!soft_rst_in) begin
          rstStateNext = HOLD;
          holdCntNext  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (soft_rst_in)       rstStateNext = ASSERT;
        else if (holdCnt == 0) rstStateNext = RUN;
        else                   holdCntNext  = holdCnt - 8'd1;
      end
      RUN: begin
        if (soft_rst_in) rstStateNext = ASSERT;
      end
      default: rstStateNext = ASSERT;
    endcase
  end

  assign afu_rst = afuRst;

  // Masking at the AFU side lets entries already in flight drain to the shell unmodified.
  assign txGated = afuRst ? f_mask_tx(afu_tx) : afu_tx;

  ccip_delay_line #(
    .T     (t_if_ccip_Rx),
    .DEPTH (RX_STAGES)
  ) rxLine (
    .clk (clk),
    .rst (rst),
    .d   (sRx_in),
    .q   (afu_rx)
  );

  ccip_delay_line #(
    .T     (t_if_ccip_Tx),
    .DEPTH (TX_STAGES)
  ) txLine (
    .clk (clk),
    .rst (rst),
    .d   (txGated),
    .q   (sTx_out)
  );

`ifdef CCIP_BOUNDARY_STATS_EN
  logic [31:0] rxRspCnt, txReqCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxRspCnt <= '0;
      txReqCnt <= '0;
    end else if (afuRst) begin
      rxRspCnt <= '0;
      txReqCnt <= '0;
    end else begin
      rxRspCnt <= rxRspCnt + 32'(afu_rx.c0.rspValid) + 32'(afu_rx.c1.rspValid);
      txReqCnt <= txReqCnt + 32'(sTx_out.c0.valid) + 32'(sTx_out.c1.valid);
    end
  end

  assign rx_rsp_cnt = rxRspCnt;
  assign tx_req_cnt = txReqCnt;
`endif

endmodule

// File: tb/tb_ccip_boundary_pipe.sv
// Randomized bench for ccip_boundary_pipe: a piped instance and a zero-stage passthrough instance.
module tb_ccip_boundary_pipe;
  import ccip_boundary_pkg::*;

  localparam int RX       = 2;
  localparam int TX       = 3;
  localparam int HOLD_CYC = 16;
  localparam int HOLD0    = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        softRst;
  t_if_ccip_Rx sRx;
  t_if_ccip_Tx afuTx;
  t_if_ccip_Tx sTx, sTx0;
  t_if_ccip_Rx afuRx, afuRx0;
  logic        afuRst, afuRst0;
`ifdef CCIP_BOUNDARY_STATS_EN
  logic [31:0] rxCnt, txCnt, rxCnt0, txCnt0;
`endif

  always #5 clk = ~clk;

  ccip_boundary_pipe #(
    .RX_STAGES(RX), .TX_STAGES(TX), .RST_HOLD(HOLD_CYC), .ALMFULL_SLACK(8)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_in(softRst),
    .sRx_in(sRx), .sTx_out(sTx), .afu_rst(afuRst), .afu_rx(afuRx), .afu_tx(afuTx)
`ifdef CCIP_BOUNDARY_STATS_EN
    , .rx_rsp_cnt(rxCnt), .tx_req_cnt(txCnt)
`endif
  );

  ccip_boundary_pipe #(
    .RX_STAGES(0), .TX_STAGES(0), .RST_HOLD(HOLD0), .ALMFULL_SLACK(8)
  ) dut0 (
    .clk(clk), .rst(rst), .soft_rst_in(softRst),
    .sRx_in(sRx), .sTx_out(sTx0), .afu_rst(afuRst0), .afu_rx(afuRx0), .afu_tx(afuTx)
`ifdef CCIP_BOUNDARY_STATS_EN
    , .rx_rsp_cnt(rxCnt0), .tx_req_cnt(txCnt0)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since the last reset source was seen, plus per-direction history.
  int          quiet;
  t_if_ccip_Tx txHist[$];
  t_if_ccip_Rx rxHist[$];

  function automatic bit modelRst(input int hold);
    return quiet <= hold;
  endfunction

  function automatic t_if_ccip_Tx modelMask(input t_if_ccip_Tx t, input bit inRst);
    t_if_ccip_Tx m;
    m = t;
    if (inRst) begin
      m.c0.valid       = 1'b0;
      m.c1.valid       = 1'b0;
      m.c2.mmioRdValid = 1'b0;
    end
    return m;
  endfunction

  function automatic t_if_ccip_Tx randTx();
    logic [$bits(t_if_ccip_Tx)-1:0] v;
    for (int i = 0; i < $bits(v); i++) v[i] = 1'($urandom);
    return t_if_ccip_Tx'(v);
  endfunction

  function automatic t_if_ccip_Rx randRx();
    logic [$bits(t_if_ccip_Rx)-1:0] v;
    for (int i = 0; i < $bits(v); i++) v[i] = 1'($urandom);
    return t_if_ccip_Rx'(v);
  endfunction

  task automatic modelReset();
    quiet = 0;
    txHist.delete();
    rxHist.delete();
    for (int i = 0; i < TX; i++) txHist.push_back('0);
    for (int i = 0; i < RX; i++) rxHist.push_back('0);
  endtask

  // One clock: record what the pipes capture, advance, then update the reset model.
  task automatic tick();
    txHist.push_front(modelMask(afuTx, modelRst(HOLD_CYC)));
    void'(txHist.pop_back());
    rxHist.push_front(sRx);
    void'(rxHist.pop_back());
    @(posedge clk);
    #1;
    if (softRst) quiet = 0;
    else if (quiet < 1000) quiet++;
  endtask

  task automatic waitRun();
    for (int i = 0; i < 100 && modelRst(HOLD_CYC); i++) tick();
    total++;
    if (afuRst !== 1'b0) begin
      bad++;
      $display("FAIL wait_run: afu_rst=%b, expected 0 after hold window", afuRst);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    softRst = 1'b0;
    sRx     = randRx();
    afuTx   = randTx();
    afuTx.c1.valid = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (afuRst !== 1'b1) begin bad++; $display("FAIL reset_afu_rst: got %b want 1", afuRst); end
    total++;
    if (sTx !== '0) begin bad++; $display("FAIL reset_stx: got %h want 0", sTx); end
    total++;
    if (afuRx !== '0) begin bad++; $display("FAIL reset_afu_rx: got %h want 0", afuRx); end
    total++;
    if (afuRst0 !== 1'b1) begin bad++; $display("FAIL reset_afu_rst0: got %b want 1", afuRst0); end
    total++;
    if ({sTx0.c0.valid, sTx0.c1.valid, sTx0.c2.mmioRdValid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_stx0_mask: valids got %b want 000",
               {sTx0.c0.valid, sTx0.c1.valid, sTx0.c2.mmioRdValid});
    end
  endtask

  task automatic test_release();
    int fallCyc  = -1;
    int validCyc = -1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      total++;
      if (afuRst !== modelRst(HOLD_CYC)) begin
        bad++;
        $display("FAIL release_afu_rst cyc=%0d: got %b want %b", cyc, afuRst, modelRst(HOLD_CYC));
      end
      total++;
      if (sTx !== txHist[TX-1]) begin
        bad++;
        $display("FAIL release_stx cyc=%0d: got %h want %h", cyc, sTx, txHist[TX-1]);
      end
      if (fallCyc < 0 && afuRst === 1'b0) fallCyc = cyc;
      if (validCyc < 0 && sTx.c1.valid === 1'b1) validCyc = cyc;
    end
    total++;
    if (fallCyc != HOLD_CYC) begin
      bad++;
      $display("FAIL release_fall_cycle: got %0d want %0d", fallCyc, HOLD_CYC);
    end
    total++;
    if (validCyc != HOLD_CYC + TX) begin
      bad++;
      $display("FAIL release_first_valid: got %0d want %0d", validCyc, HOLD_CYC + TX);
    end
  endtask

  task automatic test_rx_pulse();
    t_if_ccip_Rx pulse;
    int hits   = 0;
    int hitCyc = -1;
    sRx   = randRx();
    sRx.c0.rspValid = 1'b0;
    sRx.c1.rspValid = 1'b0;
    pulse = randRx();
    pulse.c0.rspValid = 1'b1;
    pulse.c1.rspValid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 2) sRx = pulse;
      else if (cyc == 3) begin
        sRx = randRx();
        sRx.c0.rspValid = 1'b0;
        sRx.c1.rspValid = 1'b0;
      end
      tick();
      total++;
      if (afuRx !== rxHist[RX-1]) begin
        bad++;
        $display("FAIL rx_pulse_data cyc=%0d: got %h want %h", cyc, afuRx, rxHist[RX-1]);
      end
      if (afuRx.c0.rspValid === 1'b1) begin
        hits++;
        hitCyc = cyc;
        total++;
        if (afuRx.c0 !== pulse.c0) begin
          bad++;
          $display("FAIL rx_pulse_payload: got %h want %h", afuRx.c0, pulse.c0);
        end
      end
    end
    total++;
    if (hits != 1 || hitCyc != 2 + RX - 1) begin
      bad++;
      $display("FAIL rx_pulse_timing: hits=%0d at cyc %0d, want 1 at cyc %0d", hits, hitCyc, 2 + RX - 1);
    end
  endtask

  task automatic test_soft_reset();
    int highCnt  = 0;
    int high0Cnt = 0;
    int drain    = 0;
    softRst = 1'b0;
    waitRun();
    afuTx = randTx();
    afuTx.c0.valid = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 32; i++) begin
      softRst = (i == 0);
      tick();
      total++;
      if (afuRst !== modelRst(HOLD_CYC)) begin
        bad++;
        $display("FAIL soft_afu_rst i=%0d: got %b want %b", i, afuRst, modelRst(HOLD_CYC));
      end
      total++;
      if (sTx !== txHist[TX-1]) begin
        bad++;
        $display("FAIL soft_stx i=%0d: got %h want %h", i, sTx, txHist[TX-1]);
      end
      if (afuRst === 1'b1) highCnt++;
      if (afuRst0 === 1'b1) high0Cnt++;
      if (afuRst === 1'b1 && sTx.c0.valid === 1'b1) drain++;
    end
    softRst = 1'b0;
    total++;
    if (highCnt != HOLD_CYC + 1) begin
      bad++;
      $display("FAIL soft_hold_len: got %0d want %0d", highCnt, HOLD_CYC + 1);
    end
    total++;
    if (high0Cnt != HOLD0 + 1) begin
      bad++;
      $display("FAIL soft_hold_len0: got %0d want %0d", high0Cnt, HOLD0 + 1);
    end
    total++;
    if (drain != TX) begin
      bad++;
      $display("FAIL soft_drain: got %0d in-flight valids want %0d", drain, TX);
    end
  endtask

  task automatic test_async_reset();
    waitRun();
    sRx   = randRx();
    sRx.c0.rspValid = 1'b1;
    afuTx = randTx();
    afuTx.c0.valid = 1'b1;
    repeat (TX + 1) tick();
    total++;
    if (sTx !== txHist[TX-1] || sTx.c0.valid !== 1'b1) begin
      bad++;
      $display("FAIL async_prefill: got %h want %h", sTx, txHist[TX-1]);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (sTx !== '0) begin bad++; $display("FAIL async_stx: got %h want 0", sTx); end
    total++;
    if (afuRx !== '0) begin bad++; $display("FAIL async_afu_rx: got %h want 0", afuRx); end
    total++;
    if (afuRst !== 1'b1) begin bad++; $display("FAIL async_afu_rst: got %b want 1", afuRst); end
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 50 && modelRst(HOLD0); i++) tick();
    for (int i = 0; i < 10; i++) begin
      sRx   = randRx();
      afuTx = randTx();
      #1;
      total++;
      if (afuRx0 !== sRx) begin
        bad++;
        $display("FAIL pass_rx i=%0d: got %h want %h", i, afuRx0, sRx);
      end
      total++;
      if (sTx0 !== afuTx) begin
        bad++;
        $display("FAIL pass_tx i=%0d: got %h want %h", i, sTx0, afuTx);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 300; cyc++) begin
      sRx     = randRx();
      afuTx   = randTx();
      softRst = ($urandom_range(0, 39) == 0);
      tick();
      total++;
      if (afuRst !== modelRst(HOLD_CYC)) begin
        bad++;
        $display("FAIL rand_afu_rst cyc=%0d: got %b want %b", cyc, afuRst, modelRst(HOLD_CYC));
      end
      total++;
      if (sTx !== txHist[TX-1]) begin
        bad++;
        $display("FAIL rand_stx cyc=%0d: got %h want %h", cyc, sTx, txHist[TX-1]);
      end
      total++;
      if (afuRx !== rxHist[RX-1]) begin
        bad++;
        $display("FAIL rand_afu_rx cyc=%0d: got %h want %h", cyc, afuRx, rxHist[RX-1]);
      end
      total++;
      if (afuRst0 !== modelRst(HOLD0)) begin
        bad++;
        $display("FAIL rand_afu_rst0 cyc=%0d: got %b want %b", cyc, afuRst0, modelRst(HOLD0));
      end
      total++;
      if (sTx0 !== modelMask(afuTx, modelRst(HOLD0))) begin
        bad++;
        $display("FAIL rand_stx0 cyc=%0d: got %h want %h", cyc, sTx0, modelMask(afuTx, modelRst(HOLD0)));
      end
      total++;
      if (afuRx0 !== sRx) begin
        bad++;
        $display("FAIL rand_afu_rx0 cyc=%0d: got %h want %h", cyc, afuRx0, sRx);
      end
    end
    softRst = 1'b0;
  endtask

`ifdef CCIP_BOUNDARY_STATS_EN
  task automatic test_stats();
    softRst = 1'b0;
    sRx = randRx();
    sRx.c0.rspValid = 1'b0;
    sRx.c1.rspValid = 1'b0;
    afuTx = randTx();
    waitRun();
    repeat (RX + 1) tick();
    sRx.c0.rspValid = 1'b1;
    sRx.c1.rspValid = 1'b1;
    tick();
    sRx.c0.rspValid = 1'b0;
    sRx.c1.rspValid = 1'b0;
    repeat (RX - 1) tick();
    total++;
    if (afuRx.c0.rspValid !== 1'b1 || afuRx.c1.rspValid !== 1'b1) begin
      bad++;
      $display("FAIL stats_pulse: c0=%b c1=%b want 1 1", afuRx.c0.rspValid, afuRx.c1.rspValid);
    end
    force dut.rxRspCnt = 32'hFFFF_FFFF;
    #1;
    release dut.rxRspCnt;
    tick();
    total++;
    if (rxCnt !== 32'd1) begin
      bad++;
      $display("FAIL stats_wrap: rx_rsp_cnt got %0d want 1", rxCnt);
    end
    softRst = 1'b1;
    tick();
    softRst = 1'b0;
    tick();
    total++;
    if (txCnt !== 32'd0 || rxCnt !== 32'd0) begin
      bad++;
      $display("FAIL stats_clear: rx=%0d tx=%0d want 0 0", rxCnt, txCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_rx_pulse();
    test_soft_reset();
    test_async_reset();
    test_passthrough();
    test_random();
`ifdef CCIP_BOUNDARY_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
